// File: rtl/maquina_pkg.sv
// Shared definitions for the vending machine control: states, product codes,
// coin encoding and the price lookup.
package maquina_pkg;

  typedef enum logic [1:0] {
    ESPERA     = 2'b00,
    PRODUTO    = 2'b01,
    COMPARADOR = 2'b10,
    ENTREGA    = 2'b11
  } estado_t;

  localparam logic [3:0] COD_REFRI       = 4'b0000;
  localparam logic [3:0] COD_SALGADINHO  = 4'b0100;
  localparam logic [3:0] COD_AMENDOIM    = 4'b0101;
  localparam logic [3:0] COD_AGUA        = 4'b1000;
  localparam logic [3:0] COD_SUCO        = 4'b1001;
  localparam logic [3:0] COD_AGUA_COCO   = 4'b1010;
  localparam logic [3:0] COD_CAFE        = 4'b1011;
  localparam logic [3:0] COD_SANDUICHE   = 4'b1100;
  localparam logic [3:0] COD_SAND_NATURAL = 4'b1101;
  localparam logic [3:0] COD_INVALIDO    = 4'b1111;

  localparam logic [1:0] MOEDA_NADA = 2'b00;
  localparam logic [1:0] MOEDA_25   = 2'b01;
  localparam logic [1:0] MOEDA_50   = 2'b10;
  localparam logic [1:0] MOEDA_100  = 2'b11;

  // Highest credit the machine holds, in quarters (R$2,00)
  localparam logic [3:0] CREDITO_MAX = 4'd8;

  typedef struct packed {
    logic       valido;
    logic [3:0] quartos;
  } preco_t;

  function automatic preco_t consulta_preco(input logic [3:0] cod);
    preco_t p;
    p.valido  = 1'b1;
    p.quartos = 4'd0;
    case (cod)
      COD_REFRI:        p.quartos = 4'd6;
      COD_SALGADINHO:   p.quartos = 4'd5;
      COD_AMENDOIM:     p.quartos = 4'd3;
      COD_AGUA:         p.quartos = 4'd4;
      COD_SUCO:         p.quartos = 4'd6;
      COD_AGUA_COCO:    p.quartos = 4'd7;
      COD_CAFE:         p.quartos = 4'd3;
      COD_SANDUICHE:    p.quartos = 4'd8;
      COD_SAND_NATURAL: p.quartos = 4'd8;
      default:          p.valido  = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic codigo_valido(input logic [3:0] cod);
    preco_t p;
    p = consulta_preco(cod);
    return p.valido;
  endfunction

  function automatic logic [3:0] valor_moeda(input logic [1:0] m);
    case (m)
      MOEDA_25:  return 4'd1;
      MOEDA_50:  return 4'd2;
      MOEDA_100: return 4'd4;
      default:   return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter: a restart loads CICLOS-1, expira_o pulses for one
// cycle once CICLOS edges have passed since the restart edge.
module temporizador #(
  parameter int CICLOS = 4,
  parameter int W      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic reinicia_i,
  input  logic para_i,
  output logic expira_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ativo_q, ativo_d;

  assign expira_o = ativo_q && (cnt_q == '0);

  // Next count: restart wins over stop/expiry so a re-arm on the expiry edge holds
  always_comb begin
    cnt_d   = cnt_q;
    ativo_d = ativo_q;
    if (reinicia_i) begin
      cnt_d   = W'(CICLOS - 1);
      ativo_d = 1'b1;
    end else if (para_i || expira_o) begin
      cnt_d   = '0;
      ativo_d = 1'b0;
    end else if (ativo_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ativo_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ativo_q <= ativo_d;
    end
  end

endmodule

// File: rtl/controle_maquina.sv
// Main control FSM of the vending machine: code selection, coin credit,
// delivery with change, cancel/timeout refund and rejected-coin warning.
module controle_maquina
  import maquina_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 500_000_000,
  parameter int AVISO_CICLOS   = 100_000_000,
  parameter int ENTREGA_CICLOS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirmar,
  input  logic       cancelar,
  input  logic [3:0] codigo,
  input  logic [1:0] moeda,
  output logic [1:0] estado,
  output logic [3:0] produto,
  output logic [3:0] valorMoedas,
  output logic       devolver,
  output logic       liberar,
  output logic [3:0] troco,
  output logic       troco_valido
);

  localparam int MAX_AB  = (TIMEOUT_CICLOS > AVISO_CICLOS) ? TIMEOUT_CICLOS : AVISO_CICLOS;
  localparam int MAX_CIC = (MAX_AB > ENTREGA_CICLOS) ? MAX_AB : ENTREGA_CICLOS;
  localparam int CNT_W   = (MAX_CIC > 1) ? $clog2(MAX_CIC) : 1;

  estado_t    estado_q, estado_d;
  logic [3:0] produto_q, produto_d;
  logic [3:0] valor_q, valor_d;
  logic       devolver_q, devolver_d;
  logic       liberar_q, liberar_d;
  logic [3:0] troco_q, troco_d;
  logic       troco_valido_q, troco_valido_d;

  logic       exp_timeout, exp_aviso, exp_entrega;
  logic       rearma_aviso, para_aviso;
  logic       evento, em_ativa;
  logic       reinicia_to, para_to;
  logic       reinicia_ent, para_ent;
  logic [4:0] soma;
  preco_t     preco_atual;

  assign preco_atual = consulta_preco(produto_q);
  assign soma        = {1'b0, valor_q} + {1'b0, valor_moeda(moeda)};

  // Inactivity timer runs only while waiting on the customer (PRODUTO/COMPARADOR)
  assign evento      = ((estado_q == PRODUTO) && confirmar) ||
                       ((estado_q == COMPARADOR) && (moeda != MOEDA_NADA));
  assign em_ativa    = (estado_d == PRODUTO) || (estado_d == COMPARADOR);
  assign reinicia_to = em_ativa && ((estado_d != estado_q) || evento);
  assign para_to     = !em_ativa;

  assign reinicia_ent = (estado_q != ENTREGA) && (estado_d == ENTREGA);
  assign para_ent     = (estado_d != ENTREGA);

  temporizador #(.CICLOS(TIMEOUT_CICLOS), .W(CNT_W)) u_timeout (
    .clk(clk), .rst(rst), .reinicia_i(reinicia_to), .para_i(para_to), .expira_o(exp_timeout)
  );

  temporizador #(.CICLOS(AVISO_CICLOS), .W(CNT_W)) u_aviso (
    .clk(clk), .rst(rst), .reinicia_i(rearma_aviso), .para_i(para_aviso), .expira_o(exp_aviso)
  );

  temporizador #(.CICLOS(ENTREGA_CICLOS), .W(CNT_W)) u_entrega (
    .clk(clk), .rst(rst), .reinicia_i(reinicia_ent), .para_i(para_ent), .expira_o(exp_entrega)
  );

  // Next state and next output values; priority cancelar > moeda > confirmar
  always_comb begin
    estado_d       = estado_q;
    produto_d      = produto_q;
    valor_d        = valor_q;
    devolver_d     = devolver_q;
    liberar_d      = 1'b0;
    troco_d        = troco_q;
    troco_valido_d = 1'b0;
    rearma_aviso   = 1'b0;
    para_aviso     = 1'b0;

    if (exp_aviso) devolver_d = 1'b0;

    case (estado_q)
      ESPERA: begin
        if (!cancelar && confirmar) begin
          produto_d = codigo_valido(codigo) ? codigo : COD_INVALIDO;
          estado_d  = PRODUTO;
        end
      end

      PRODUTO: begin
        if (cancelar || exp_timeout) begin
          estado_d = ESPERA;
        end else if (confirmar) begin
          if (preco_atual.valido) estado_d = COMPARADOR;
          else produto_d = codigo_valido(codigo) ? codigo : COD_INVALIDO;
        end
      end

      COMPARADOR: begin
        if (cancelar || exp_timeout) begin
          troco_d        = valor_q;
          troco_valido_d = (valor_q != 4'd0);
          valor_d        = 4'd0;
          estado_d       = ESPERA;
        end else if (moeda != MOEDA_NADA) begin
          if (soma > {1'b0, CREDITO_MAX}) begin
            // Rejected coin: credit untouched, warning (re)armed
            devolver_d   = 1'b1;
            rearma_aviso = 1'b1;
          end else begin
            valor_d    = soma[3:0];
            devolver_d = 1'b0;
            para_aviso = 1'b1;
            if (soma[3:0] >= preco_atual.quartos) begin
              estado_d       = ENTREGA;
              liberar_d      = 1'b1;
              troco_d        = soma[3:0] - preco_atual.quartos;
              troco_valido_d = 1'b1;
            end
          end
        end
      end

      ENTREGA: begin
        if (exp_entrega) begin
          valor_d   = 4'd0;
          produto_d = COD_REFRI;
          estado_d  = ESPERA;
        end
      end

      default: estado_d = ESPERA;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q       <= ESPERA;
      produto_q      <= 4'b0000;
      valor_q        <= 4'd0;
      devolver_q     <= 1'b0;
      liberar_q      <= 1'b0;
      troco_q        <= 4'd0;
      troco_valido_q <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      produto_q      <= produto_d;
      valor_q        <= valor_d;
      devolver_q     <= devolver_d;
      liberar_q      <= liberar_d;
      troco_q        <= troco_d;
      troco_valido_q <= troco_valido_d;
    end
  end

  assign estado       = estado_q;
  assign produto      = produto_q;
  assign valorMoedas  = valor_q;
  assign devolver     = devolver_q;
  assign liberar      = liberar_q;
  assign troco        = troco_q;
  assign troco_valido = troco_valido_q;

endmodule
